risc_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RISC core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the instruction decoder's enable (cnt), the ALU, data memory, register-file write and PC update, all from the decoded opcode/func fields. It also includes a memory-wait watchdog and a retired-instruction counter.

---
 rtl/risc_ctrl_fsm.sv | 196 +++++++++++++++++++
 tb/tb_risc_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_ctrl_fsm.sv
//------------------------------------------------------------------------------
// risc_ctrl_fsm : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//                 with memory-wait watchdog and retired-instruction counter.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module risc_ctrl_fsm #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             cnt,
    output logic             alu_en,
    output logic [3:0]       alu_op,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ill,
    output logic             err,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] c_OP_R     = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h01;
    localparam logic [5:0] c_OP_LOAD  = 6'h02;
    localparam logic [5:0] c_OP_STORE = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_JMP   = 6'h05;
    localparam logic [5:0] c_OP_HALT  = 6'h3F;
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic [5:0]       r_func;
    logic [7:0]       r_wait;
    logic             r_err;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_fault;
    logic             w_tmo;

    // The fault fires on the cycle that would make the wait count reach TIMEOUT;
    // an ack in that same cycle takes priority.
    assign w_tmo   = (r_wait == c_WAIT_LAST);
    assign state   = r_state;
    assign err     = r_err;
    assign retired = r_retired;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_fault  = 1'b0;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        cnt      = 1'b0;
        alu_en   = 1'b0;
        alu_op   = 4'd0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        reg_wr   = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 2'd0;
        ill      = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_tmo) begin
                    w_fault = 1'b1;
                    w_next  = S_HALT;
                end
            end
            S_DECODE: begin
                cnt = 1'b1;
                case (opcode)
                    c_OP_HALT: w_next = S_HALT;
                    c_OP_R, c_OP_ADDI, c_OP_LOAD,
                    c_OP_STORE, c_OP_BEQ, c_OP_JMP: w_next = S_EXEC;
                    default: begin
                        ill      = 1'b1;
                        pc_en    = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (r_op)
                    c_OP_R: begin
                        alu_op = r_func[3:0];
                        w_next = S_WB;
                    end
                    c_OP_ADDI:             w_next = S_WB;
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEM;
                    c_OP_BEQ: begin
                        alu_op   = 4'd1;
                        pc_en    = 1'b1;
                        pc_sel   = zero ? 2'd1 : 2'd0;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    c_OP_JMP: begin
                        pc_en    = 1'b1;
                        pc_sel   = 2'd2;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_rd = (r_op == c_OP_LOAD);
                mem_wr = (r_op == c_OP_STORE);
                if (dmem_ack) begin
                    if (r_op == c_OP_STORE) begin
                        pc_en    = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_tmo) begin
                    w_fault = 1'b1;
                    w_next  = S_HALT;
                end
            end
            S_WB: begin
                reg_wr   = 1'b1;
                pc_en    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_op      <= 6'd0;
            r_func    <= 6'd0;
            r_wait    <= 8'd0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op   <= opcode;
                r_func <= func;
            end
            if (w_next != r_state)
                r_wait <= 8'd0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_wait <= r_wait + 8'd1;
            r_err <= r_err | w_fault;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_risc_ctrl_fsm.sv
//------------------------------------------------------------------------------
// tb_risc_ctrl_fsm : randomized self-checking bench for risc_ctrl_fsm.
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_risc_ctrl_fsm;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic [5:0]       func = 6'd0;
    logic             zero = 1'b0;
    logic             imem_ack = 1'b0;
    logic             dmem_ack = 1'b0;
    logic             imem_req, ir_load, cnt, alu_en, mem_rd, mem_wr;
    logic             reg_wr, pc_en, ill, err, halted;
    logic [3:0]       alu_op;
    logic [1:0]       pc_sel;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    risc_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .opcode(opcode), .func(func),
        .zero(zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_load(ir_load), .cnt(cnt), .alu_en(alu_en),
        .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .pc_en(pc_en), .pc_sel(pc_sel), .ill(ill), .err(err), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // One expected clock cycle: the inputs to apply and the outputs required.
    typedef struct {
        logic       start, iack, dack, zero;
        logic [5:0] opc, fn;
        logic [2:0] st;
        logic       imem_req, ir_load, cnt, alu_en;
        logic [3:0] alu_op;
        logic       mem_rd, mem_wr, reg_wr, pc_en;
        logic [1:0] pc_sel;
        logic       ill, err, halted;
        bit         ret;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_ret  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t blank(input int st);
        cyc_t c;
        c = '{default: '0};
        c.st   = 3'(st);
        c.opc  = 6'($urandom);
        c.fn   = 6'($urandom);
        c.iack = 1'($urandom);
        c.dack = 1'($urandom);
        c.zero = 1'($urandom);
        return c;
    endfunction

    function automatic logic [31:0] pack_exp(input cyc_t c);
        return {12'd0, c.st, c.imem_req, c.ir_load, c.cnt, c.alu_en, c.alu_op,
                c.mem_rd, c.mem_wr, c.reg_wr, c.pc_en, c.pc_sel, c.ill, c.err, c.halted};
    endfunction

    function automatic logic [31:0] pack_dut();
        return {12'd0, state, imem_req, ir_load, cnt, alu_en, alu_op,
                mem_rd, mem_wr, reg_wr, pc_en, pc_sel, ill, err, halted};
    endfunction

    task automatic push_halt(input logic er);
        cyc_t c;
        for (int k = 0; k < 3; k++) begin
            c = blank(6);
            c.halted = 1'b1;
            c.err    = er;
            q.push_back(c);
        end
    endtask

    // Expand one instruction into its expected per-cycle trace.
    task automatic gen_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input int fd, input int md, input logic z, output bit ended);
        cyc_t c;
        bit   legal;
        ended = 1'b0;
        legal = (opc <= 6'h05);
        for (int k = 0; k < fd && k < TIMEOUT; k++) begin
            c = blank(1); c.iack = 1'b0; c.imem_req = 1'b1; q.push_back(c);
        end
        if (fd >= TIMEOUT) begin push_halt(1'b1); ended = 1'b1; return; end
        c = blank(1); c.iack = 1'b1; c.imem_req = 1'b1; c.ir_load = 1'b1; q.push_back(c);
        c = blank(2); c.opc = opc; c.fn = fn; c.cnt = 1'b1;
        if (opc == 6'h3F) begin q.push_back(c); push_halt(1'b0); ended = 1'b1; return; end
        if (!legal) begin c.ill = 1'b1; c.pc_en = 1'b1; c.ret = 1'b1; q.push_back(c); return; end
        q.push_back(c);
        c = blank(3); c.alu_en = 1'b1; c.zero = z;
        c.alu_op = (opc == 6'h00) ? fn[3:0] : (opc == 6'h04) ? 4'd1 : 4'd0;
        if (opc == 6'h04 || opc == 6'h05) begin
            c.pc_en  = 1'b1;
            c.pc_sel = (opc == 6'h05) ? 2'd2 : (z ? 2'd1 : 2'd0);
            c.ret    = 1'b1;
            q.push_back(c);
            return;
        end
        q.push_back(c);
        if (opc == 6'h02 || opc == 6'h03) begin
            for (int k = 0; k < md && k < TIMEOUT; k++) begin
                c = blank(4); c.dack = 1'b0;
                c.mem_rd = (opc == 6'h02); c.mem_wr = (opc == 6'h03);
                q.push_back(c);
            end
            if (md >= TIMEOUT) begin push_halt(1'b1); ended = 1'b1; return; end
            c = blank(4); c.dack = 1'b1;
            c.mem_rd = (opc == 6'h02); c.mem_wr = (opc == 6'h03);
            if (opc == 6'h03) begin c.pc_en = 1'b1; c.ret = 1'b1; q.push_back(c); return; end
            q.push_back(c);
        end
        c = blank(5); c.reg_wr = 1'b1; c.pc_en = 1'b1; c.ret = 1'b1; q.push_back(c);
    endtask

    function automatic int rand_delay(input bit safe);
        int r;
        r = $urandom_range(0, 29);
        if (safe || r < 24) return $urandom_range(0, 3);
        if (r < 28) return TIMEOUT - 1;
        return TIMEOUT;
    endfunction

    task automatic gen_random(input bit safe, output bit ended);
        logic [5:0] opc;
        int r;
        r = $urandom_range(0, 19);
        if (safe || r < 16) opc = 6'($urandom_range(0, 5));
        else if (r < 19)    opc = 6'($urandom_range(6, 62));
        else                opc = 6'h3F;
        gen_instr(opc, 6'($urandom), rand_delay(safe), rand_delay(safe), 1'($urandom), ended);
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            start = c.start; imem_ack = c.iack; dmem_ack = c.dack;
            zero = c.zero; opcode = c.opc; func = c.fn;
            @(negedge clk);
            check($sformatf("out_st%0d", c.st), pack_dut(), pack_exp(c));
            check("retired", 32'(retired), 32'(exp_ret % (1 << CNT_W)));
            if (c.ret) exp_ret++;
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset: outputs must clear without a clock edge, acks ignored.
    task automatic do_reset();
        cyc_t c;
        start = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        rstn = 1'b0;
        #1;
        check("rst_async", pack_dut(), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        check("rst_held", pack_dut(), 32'd0);
        #2 rstn = 1'b1;
        exp_ret = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin c = blank(0); q.push_back(c); end
        c = blank(0); c.start = 1'b1; q.push_back(c);
    endtask

    bit ended;

    initial begin
        #1;
        do_reset();
        gen_instr(6'h00, 6'h02, 0, 0, 1'b0, ended);
        gen_instr(6'h02, 6'h11, 0, 3, 1'b0, ended);
        gen_instr(6'h03, 6'h00, 1, 0, 1'b0, ended);
        gen_instr(6'h04, 6'h00, 0, 0, 1'b1, ended);
        gen_instr(6'h04, 6'h00, 0, 0, 1'b0, ended);
        gen_instr(6'h05, 6'h00, 0, 0, 1'b1, ended);
        gen_instr(6'h10, 6'h00, 0, 0, 1'b0, ended);
        gen_instr(6'h01, 6'h07, TIMEOUT - 1, 0, 1'b0, ended);
        gen_instr(6'h00, 6'h2A, 2, 0, 1'b0, ended);
        gen_instr(6'h02, 6'h00, 0, TIMEOUT - 1, 1'b0, ended);
        gen_instr(6'h3F, 6'h00, 0, 0, 1'b0, ended);
        run_q();

        do_reset();
        gen_instr(6'h01, 6'h00, TIMEOUT, 0, 1'b0, ended);
        run_q();

        do_reset();
        gen_instr(6'h02, 6'h00, 0, TIMEOUT, 1'b0, ended);
        run_q();

        // Enough retirements to wrap the narrow counter, then abort mid-MEM.
        do_reset();
        for (int i = 0; i < 20; i++) gen_random(1'b1, ended);
        gen_instr(6'h02, 6'h00, 0, 6, 1'b0, ended);
        while (q.size() > 0 && q[q.size()-1].st != 3'd4) void'(q.pop_back());
        repeat (4) void'(q.pop_back());
        run_q();
        do_reset();
        run_q();

        for (int e = 0; e < 10; e++) begin
            do_reset();
            for (int i = 0; i < 25; i++) begin
                gen_random(1'b0, ended);
                if (ended) break;
            end
            run_q();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
